// File: rtl/online_adder_sd_pkg.sv
// Shared definitions for the signed-digit (borrow-save) online adder.
package online_adder_sd_pkg;

    localparam int P_BIT = 1;
    localparam int N_BIT = 0;

    function automatic int digit_width(input int n);
        return 2 * n;
    endfunction

    // Returns {carry, sum} of a one-bit full adder.
    function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
        return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
    endfunction

endpackage

// File: rtl/sd_adder_cell.sv
// One digit of the carry-free signed-digit adder: two full-adder levels whose
// carries move exactly one position left, so the chain never ripples.
module sd_adder_cell
    import online_adder_sd_pkg::*;
(
    input  logic xp,
    input  logic xn,
    input  logic yp,
    input  logic yn,
    input  logic h_in,
    input  logic g_in,
    output logic h_out,
    output logic g_out,
    output logic zp,
    output logic zn
);

    logic [1:0] lvl1_s;
    logic [1:0] lvl2_s;
    logic       t_s;

    // Level 1 folds xp - xn + yp into 2*h_out - t; level 2 folds h_in - t - yn.
    always_comb begin
        lvl1_s = full_add(xp, yp, ~xn);
        t_s    = ~lvl1_s[0];
        lvl2_s = full_add(~h_in, t_s, yn);
    end

    assign h_out = lvl1_s[1];
    assign g_out = lvl2_s[1];
    assign zp    = ~lvl2_s[0];
    assign zn    = g_in;

endmodule

// File: rtl/online_adder_sd.sv
// Registered radix-2 signed-digit adder: z = x + y + cin with Stage+1 output digits,
// logic depth independent of Stage.
module online_adder_sd
    import online_adder_sd_pkg::*;
#(
    parameter int Stage = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [digit_width(Stage)-1:0]   x,
    input  logic [digit_width(Stage)-1:0]   y,
    input  logic                            cin,
    output logic [digit_width(Stage+1)-1:0] z
);

    localparam int ZW = digit_width(Stage + 1);

    logic [Stage:0]  h_s;
    logic [Stage:0]  g_s;
    logic [ZW-1:0]   sum_s;
    logic [ZW-1:0]   z_r;

    assign h_s[0] = cin;
    assign g_s[0] = 1'b0;

    for (genvar i = 0; i < Stage; i++) begin : g_digit
        sd_adder_cell u_cell (
            .xp    (x[2*i+P_BIT]),
            .xn    (x[2*i+N_BIT]),
            .yp    (y[2*i+P_BIT]),
            .yn    (y[2*i+N_BIT]),
            .h_in  (h_s[i]),
            .g_in  (g_s[i]),
            .h_out (h_s[i+1]),
            .g_out (g_s[i+1]),
            .zp    (sum_s[2*i+P_BIT]),
            .zn    (sum_s[2*i+N_BIT])
        );
    end

    // The leftover level-1 and level-2 carries form the extra top digit.
    assign sum_s[2*Stage+P_BIT] = h_s[Stage];
    assign sum_s[2*Stage+N_BIT] = g_s[Stage];

    // Output register with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            z_r <= {ZW{1'b0}};
        end else begin
            z_r <= sum_s;
        end
    end

    assign z = z_r;

endmodule

// File: tb/tb_online_adder_sd.sv
// Self-checking bench for online_adder_sd at Stage=4 and Stage=8, comparing
// the numeric value of z against integer arithmetic on the operand values.
module tb_online_adder_sd;

    logic        clk;
    logic        rst;
    logic        cin;
    logic [7:0]  x4;
    logic [7:0]  y4;
    logic [9:0]  z4;
    logic [15:0] x8;
    logic [15:0] y8;
    logic [17:0] z8;

    int checks;
    int errors;
    int e4;
    int e8;

    online_adder_sd #(.Stage(4)) dut4 (
        .clk (clk), .rst (rst), .x (x4), .y (y4), .cin (cin), .z (z4)
    );

    online_adder_sd #(.Stage(8)) dut8 (
        .clk (clk), .rst (rst), .x (x8), .y (y8), .cin (cin), .z (z8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int sd_val(input logic [17:0] v, input int nd);
        int acc;
        acc = 0;
        for (int i = 0; i < nd; i++) begin
            acc += (int'(v[2*i+1]) - int'(v[2*i])) * (1 << i);
        end
        return acc;
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Clock one edge, predict from the inputs present at that edge, sample 1 ns later.
    task automatic step(input string tag);
        @(posedge clk);
        e4 = rst ? 0 : sd_val({10'd0, x4}, 4) + sd_val({10'd0, y4}, 4) + int'(cin);
        e8 = rst ? 0 : sd_val({2'd0, x8}, 8) + sd_val({2'd0, y8}, 8) + int'(cin);
        #1;
        check({tag, "_z4"}, sd_val({8'd0, z4}, 5), e4);
        check({tag, "_z8"}, sd_val(z8, 9), e8);
    endtask

    task automatic randomize_inputs();
        x4  = 8'($urandom);
        y4  = 8'($urandom);
        x8  = 16'($urandom);
        y8  = 16'($urandom);
        cin = 1'($urandom);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        randomize_inputs();

        for (int i = 0; i < 4; i++) begin
            step("reset_hold");
            check("reset_zero_bits4", int'(z4), 0);
            randomize_inputs();
        end

        rst = 1'b0;
        step("reset_release");

        x4 = 8'hAA; y4 = 8'hAA; x8 = 16'hAAAA; y8 = 16'hAAAA; cin = 1'b1;
        step("max_pos");
        check("max_pos_const4", sd_val({8'd0, z4}, 5), 31);
        check("max_pos_const8", sd_val(z8, 9), 511);

        x4 = 8'h55; y4 = 8'h55; x8 = 16'h5555; y8 = 16'h5555; cin = 1'b0;
        step("max_neg");
        check("max_neg_const4", sd_val({8'd0, z4}, 5), -30);
        check("max_neg_const8", sd_val(z8, 9), -510);

        x4 = 8'h22; y4 = 8'h11; x8 = 16'h0022; y8 = 16'h0011; cin = 1'b0;
        step("cancel");
        check("cancel_const4", sd_val({8'd0, z4}, 5), 0);

        x4 = 8'hEE; y4 = 8'h11; x8 = 16'hFFEE; y8 = 16'h0011;
        step("cancel_11");
        check("cancel_11_const4", sd_val({8'd0, z4}, 5), 0);

        x4 = 8'h00; y4 = 8'h00; x8 = 16'h0000; y8 = 16'h0000; cin = 1'b1;
        step("cin_only");
        check("cin_only_const4", sd_val({8'd0, z4}, 5), 1);
        check("cin_only_digit0", int'(z4[1:0]), 2);

        for (int i = 0; i < 10000; i++) begin
            randomize_inputs();
            if (i == 5000) begin
                rst = 1'b1;
            end else begin
                rst = 1'b0;
            end
            step("random");
            if (i == 5000) begin
                check("mid_reset_bits4", int'(z4), 0);
                check("mid_reset_bits8", int'(z8), 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
